// File: rtl/hazard_grid_pkg.sv
// rtl/hazard_grid_pkg.sv - shared grid geometry, FSM state, box type and cell indexing
package hazard_grid_pkg;

    localparam int GRID_COLS = 8;
    localparam int GRID_ROWS = 4;
    localparam int CELL_W    = 3;
    localparam int CELL_H    = 2;
    localparam int COORD_W   = 5;
    localparam int NCELLS    = GRID_COLS * GRID_ROWS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_GROW_R,
        ST_GROW_D,
        ST_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] top;
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] bottom;
        logic [COORD_W-1:0] right;
    } box_t;

    function automatic logic [4:0] cell_idx(input logic [1:0] row, input logic [2:0] col);
        return 5'(int'(row) * GRID_COLS + int'(col));
    endfunction

endpackage

// File: rtl/hazard_rect_mask.sv
// rtl/hazard_rect_mask.sv - combinational 32-cell mask of an inclusive cell rectangle
module hazard_rect_mask
    import hazard_grid_pkg::*;
(
    input  logic [1:0]        start_row,
    input  logic [2:0]        start_col,
    input  logic [1:0]        end_row,
    input  logic [2:0]        end_col,
    output logic [NCELLS-1:0] mask
);

    logic [GRID_ROWS-1:0] row_sel;
    logic [GRID_COLS-1:0] col_sel;

    // Range selects built from opposing shifts; ~end gives (max - end) for free.
    assign row_sel = (4'hF << start_row) & (4'hF >> (~end_row));
    assign col_sel = (8'hFF << start_col) & (8'hFF >> (~end_col));

    for (genvar i = 0; i < NCELLS; i++) begin : g_cell
        assign mask[i] = row_sel[i / GRID_COLS] & col_sel[i % GRID_COLS];
    end

endmodule

// File: rtl/hazard_decoder.sv
// rtl/hazard_decoder.sv - raster-scan greedy rectangle decoder from occupancy grid to pixel boxes
module hazard_decoder #(
    parameter int GRID_COLS = 8,
    parameter int GRID_ROWS = 4,
    parameter int CELL_W    = 3,
    parameter int CELL_H    = 2,
    parameter int COORD_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        vec1,
    input  logic [15:0]        vec2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_top,
    output logic [COORD_W-1:0] out_left,
    output logic [COORD_W-1:0] out_bottom,
    output logic [COORD_W-1:0] out_right,
    output logic               out_last,
    output logic               done,
    output logic [4:0]         num_hazards
);
    import hazard_grid_pkg::*;

    localparam logic [4:0] LAST_CELL = 5'(GRID_COLS * GRID_ROWS - 1);
    localparam logic [2:0] MAX_COL   = 3'(GRID_COLS - 1);
    localparam logic [1:0] MAX_ROW   = 2'(GRID_ROWS - 1);

    state_t      state_q, state_d;
    logic [31:0] grid_q, grid_d, claimed_q, claimed_d;
    logic [4:0]  cursor_q, cursor_d, count_q, count_d, num_hazards_q, num_hazards_d;
    logic [1:0]  start_row_q, start_row_d, end_row_q, end_row_d;
    logic [2:0]  start_col_q, start_col_d, end_col_q, end_col_d;
    logic        in_ready_q, in_ready_d;

    logic [31:0] row_mask, claim_mask, unclaimed;
    logic [4:0]  right_idx;
    logic        accept, scan_hit, grow_r, grow_d, all_claimed, emit;

    hazard_rect_mask u_row_mask (
        .start_row (end_row_q + 2'd1),
        .start_col (start_col_q),
        .end_row   (end_row_q + 2'd1),
        .end_col   (end_col_q),
        .mask      (row_mask)
    );

    hazard_rect_mask u_claim_mask (
        .start_row (start_row_q),
        .start_col (start_col_q),
        .end_row   (end_row_q),
        .end_col   (end_col_q),
        .mask      (claim_mask)
    );

    assign unclaimed   = grid_q & ~claimed_q;
    assign all_claimed = (unclaimed == 32'd0);
    assign right_idx   = cell_idx(start_row_q, end_col_q + 3'd1);
    assign accept      = (state_q == ST_IDLE) && in_ready_q && in_valid;
    assign scan_hit    = unclaimed[cursor_q];
    assign grow_r      = (end_col_q < MAX_COL) && unclaimed[right_idx];
    assign grow_d      = (end_row_q < MAX_ROW) && ((unclaimed & row_mask) == row_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grid_q        <= '0;
            claimed_q     <= '0;
            cursor_q      <= '0;
            count_q       <= '0;
            num_hazards_q <= '0;
            start_row_q   <= '0;
            start_col_q   <= '0;
            end_row_q     <= '0;
            end_col_q     <= '0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grid_q        <= grid_d;
            claimed_q     <= claimed_d;
            cursor_q      <= cursor_d;
            count_q       <= count_d;
            num_hazards_q <= num_hazards_d;
            start_row_q   <= start_row_d;
            start_col_q   <= start_col_d;
            end_row_q     <= end_row_d;
            end_col_q     <= end_col_d;
            in_ready_q    <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SCAN;
            ST_SCAN:   if (scan_hit) state_d = ST_GROW_R;
                       else if (cursor_q == LAST_CELL) state_d = ST_DONE;
            ST_GROW_R: if (!grow_r) state_d = ST_GROW_D;
            ST_GROW_D: if (!grow_d) state_d = ST_EMIT;
            ST_EMIT:   if (out_ready) state_d = (all_claimed || cursor_q == LAST_CELL) ? ST_DONE : ST_SCAN;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grid_d      = grid_q;
        claimed_d   = claimed_q;
        cursor_d    = cursor_q;
        count_d     = count_q;
        start_row_d = start_row_q;
        start_col_d = start_col_q;
        end_row_d   = end_row_q;
        end_col_d   = end_col_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                grid_d    = {vec2, vec1};
                claimed_d = '0;
                cursor_d  = '0;
                count_d   = '0;
            end
            ST_SCAN: if (scan_hit) begin
                start_row_d = cursor_q[4:3];
                start_col_d = cursor_q[2:0];
                end_col_d   = cursor_q[2:0];
            end else if (cursor_q != LAST_CELL) begin
                cursor_d = cursor_q + 5'd1;
            end
            ST_GROW_R: if (grow_r) end_col_d = end_col_q + 3'd1;
                       else end_row_d = start_row_q;
            ST_GROW_D: if (grow_d) end_row_d = end_row_q + 2'd1;
                       else claimed_d = claimed_q | claim_mask;
            ST_EMIT: if (out_ready) begin
                count_d = count_q + 5'd1;
                if (!all_claimed && cursor_q != LAST_CELL) cursor_d = cursor_q + 5'd1;
            end
            default: ;
        endcase
        // Count is frozen into the report on the way into DONE; cleared on the next accept.
        num_hazards_d = accept ? 5'd0 : (state_d == ST_DONE) ? count_d : num_hazards_q;
        in_ready_d    = (state_d == ST_IDLE);
    end

    always_comb begin
        emit        = (state_q == ST_EMIT);
        in_ready    = in_ready_q;
        out_valid   = emit;
        out_last    = emit && all_claimed;
        done        = (state_q == ST_DONE);
        num_hazards = num_hazards_q;
        out_top     = '0;
        out_left    = '0;
        out_bottom  = '0;
        out_right   = '0;
        if (emit) begin
            out_top    = COORD_W'(start_row_q) * COORD_W'(CELL_H);
            out_left   = COORD_W'(start_col_q) * COORD_W'(CELL_W);
            out_bottom = COORD_W'(end_row_q) * COORD_W'(CELL_H) + COORD_W'(CELL_H - 1);
            out_right  = COORD_W'(end_col_q) * COORD_W'(CELL_W) + COORD_W'(CELL_W - 1);
        end
    end

endmodule

// File: doc/hazard_decoder.md
# hazard_decoder

Sequential decoder that converts a 32-cell hazard occupancy grid (two 16-bit row-pair vectors, the format produced by `hazard_encoder`) back into a list of rectangular hazard bounding boxes in pixel coordinates. It sits on the consumer side of the grid link. It raster-scans the grid, greedily grows maximal rectangles from unclaimed occupied cells, and streams one box per valid/ready handshake. A hazard count is reported on completion.

## Interface
- `GRID_COLS`, 8: grid columns.
- `GRID_ROWS`, 4: grid rows.
- `CELL_W`, 3: pixels per cell horizontally.
- `CELL_H`, 2: pixels per cell vertically.
- `COORD_W`, 5: pixel coordinate width. Only the defaults are supported.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  grid offered.
- `in_ready`  out  1  decoder idle and able to accept a grid.
- `vec1`  in  16  rows 0–1; bit i = row i/8, col i%8.
- `vec2`  in  16  rows 2–3; bit i = row 2+i/8, col i%8.
- `out_valid`  out  1  box fields valid.
- `out_ready`  in  1  consumer accepts the box.
- `out_top`, `out_left`, `out_bottom`, `out_right`  out  5 each  box in pixels, inclusive.
- `out_last`  out  1  this is the final box of the grid.
- `done`  out  1  one-cycle pulse, decode complete.
- `num_hazards`  out  5  boxes emitted for the last grid (0–16), held until the next accept.

## Operation
- The FSM has six states: IDLE, SCAN, GROW_R, GROW_D, EMIT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `{vec2,vec1}` as a 32-bit grid, clear the claimed mask, set cursor=0, clear the count, and go to SCAN.
- **SCAN**: examines one cell per cycle at the cursor.
  - If the cell is set and unclaimed: record start row/col, set end_col=col, and go to GROW_R.
  - Otherwise: if cursor=31, go to DONE; else cursor+1.
- **GROW_R**: one column per cycle.
  - If end_col<7 and cell (row, end_col+1) is set and unclaimed: end_col+1.
  - Otherwise: set end_row=row and go to GROW_D.
- **GROW_D**: one row per cycle.
  - If end_row<3 and every cell in cols start..end_col of row end_row+1 is set and unclaimed: end_row+1.
  - Otherwise: OR the rectangle into the claimed mask and go to EMIT.
- **EMIT**
  - `out_valid`=1 and box fields are stable until the handshake.
  - Coordinates: top=start_row·2, left=start_col·3, bottom=end_row·2+1, right=end_col·3+2.
  - `out_last` = (grid & ~claimed)==0.
  - On `out_ready`: count+1; if `out_last`, go to DONE; else if cursor=31, go to DONE; else cursor+1 and go to SCAN.
- **DONE**: `done`=1 and `num_hazards`=count for one cycle; go to IDLE.
- Decomposition of non-rectangular regions is deterministic: greedy, right-first then down, in raster order. Overlapping source hazards merge.

## Timing
- Reset values: `in_ready`=0 during reset, and 1 from the first clock after deassertion. `out_valid`, `out_last` and `done` are 0. All box fields are 0 and `num_hazards`=0. The FSM is in IDLE with grid, claimed mask and cursor cleared.
- Accept at cycle 0 puts SCAN at cell 0 in cycle 1.
- Cost per box: 1 scan hit, plus (width−1)+1 GROW_R cycles, plus (height−1)+1 GROW_D cycles, plus ≥1 EMIT cycle.
- An empty grid produces DONE in cycle 33 with `num_hazards`=0 and no `out_valid`.
- `out_valid` must not drop, and fields must not change, while `out_ready`=0. Arbitrary back-pressure is legal.
- `in_valid` outside IDLE is ignored; `in_ready` stays 0 until the cycle after DONE.
- Asserting `rst_n` low mid-decode (including during EMIT) aborts immediately. Outputs return to reset values and no partial `done` is issued.
- Coordinate maximums are 23 (right) and 7 (bottom); no overflow is possible in 5 bits.

## Structure
- Package `hazard_grid_pkg` holds:
  - `GRID_COLS`, `GRID_ROWS`, `CELL_W`, `CELL_H`, `COORD_W`;
  - the FSM state enum;
  - a `cell_idx(row,col)` function;
  - the box struct `{top,left,bottom,right}`, shared with `hazard_encoder`.
- One sub-module, `hazard_rect_mask`: combinational. It takes (start_row, start_col, end_row, end_col) and returns a 32-bit rectangle mask. It is used for both the GROW_D row check and the claim update.

## Test plan
- vec1=0xE303, vec2=0xE0E3 produces two boxes, then `done` with `num_hazards`=2:
  - box 1 is (0,0,5,5), `out_last`=0;
  - box 2 is (2,15,7,23), `out_last`=1.
- vec1=vec2=0 produces no `out_valid`; `done` fires exactly 33 cycles after accept with `num_hazards`=0.
- vec1=vec2=0xFFFF produces a single box (0,0,7,23) with `out_last`=1 and `num_hazards`=1.
- Checkerboard vec1=vec2=0xAA55 produces 16 single-cell boxes in raster order, the first being (0,0,1,2), and `num_hazards`=16.
- L-shape vec1=0x0101, vec2=0x0701 (col 0 rows 0–3 plus row 3 cols 1–2) produces box (0,0,7,2), then box (6,3,7,8).
- Hold `out_ready`=0 for 10 cycles during the first box → `out_valid` and fields stay stable. Then pulse `rst_n` low during the second box → all outputs return to reset values, and `in_ready`=1 after release.
